// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared constants for the multi-cycle RISC-V control FSM.
// State encodings, opcodes, ALU-op and ALU-B select codes, control bundle.
package rv_ctrl_pkg;

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_WB      = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;
   localparam logic [3:0] S_HALT      = 4'd9;
   localparam logic [3:0] S_I_EXEC    = 4'd10;

   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_SD   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRC_B_REG  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       pc_src;
      logic       reg_write;
      logic       mem_to_reg;
   } ctrl_t;

   // States that sit on the memory port waiting for mem_ready.
   function automatic logic is_wait_state(logic [3:0] s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// rv_multicycle_ctrl_if: unified memory port between control FSM and memory.
// master (controller): mem_read, mem_write, iord out; mem_ready in.
interface rv_multicycle_ctrl_if;

   logic mem_read;
   logic mem_write;
   logic iord;
   logic mem_ready;

   modport master (
      output mem_read,
      output mem_write,
      output iord,
      input  mem_ready
   );

   modport slave (
      input  mem_read,
      input  mem_write,
      input  iord,
      output mem_ready
   );

endinterface

// File: rtl/rv_ctrl_watchdog.sv
// rv_ctrl_watchdog: saturating memory-wait counter with sticky bus_error.
// Ports: clk, reset, waiting, mem_ready in; expire (comb), bus_error out.
module rv_ctrl_watchdog #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic waiting,
   input  logic mem_ready,
   output logic expire,
   output logic bus_error
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             stall;

   assign stall   = waiting & ~mem_ready;
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   // expire fires on the stalled cycle that brings the count to the
   // limit; a mem_ready in that same cycle suppresses it.
   generate
      if (WAIT_LIMIT > 0) begin : g_wd
         assign expire = stall && (cnt_inc == CNT_W'(WAIT_LIMIT));
      end else begin : g_no_wd
         assign expire = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         bus_error <= 1'b0;
      end else begin
         if (stall && !expire)
            cnt <= cnt_inc;
         else
            cnt <= '0;
         if (expire)
            bus_error <= 1'b1;
      end
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle RISC-V control FSM (ld, sd, R-type, beq).
// Ports: clk, reset, opcode, zero; bus (memory port, master modport);
//   alu_op, alu_src_a/b, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
//   sticky illegal/bus_error, debug state.
// Macro RV_CTRL_ADDI_EN adds addi decode through I_EXEC.
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [6:0]          opcode,
   input  logic                zero,
   rv_multicycle_ctrl_if.master bus,
   output logic [1:0]          alu_op,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_src,
   output logic                reg_write,
   output logic                mem_to_reg,
   output logic                illegal,
   output logic                bus_error,
   output logic [3:0]          state
);

   logic [3:0] state_nxt;
   logic       set_illegal;
   logic       wd_expire;
   ctrl_t      c;

   rv_ctrl_watchdog #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .CNT_W      (CNT_W)
   ) u_wd (
      .clk       (clk),
      .reset     (reset),
      .waiting   (is_wait_state(state)),
      .mem_ready (bus.mem_ready),
      .expire    (wd_expire),
      .bus_error (bus_error)
   );

   always_comb begin
      state_nxt   = state;
      set_illegal = 1'b0;
      unique case (state)
         S_FETCH:
            if (bus.mem_ready) state_nxt = S_DECODE;
         S_DECODE:
            case (opcode)
               OP_LD, OP_SD: state_nxt = S_MEM_ADDR;
               OP_R:         state_nxt = S_R_EXEC;
               OP_BEQ:       state_nxt = S_BRANCH;
`ifdef RV_CTRL_ADDI_EN
               OP_ADDI:      state_nxt = S_I_EXEC;
`endif
               default: begin
                  state_nxt   = S_HALT;
                  set_illegal = 1'b1;
               end
            endcase
         S_MEM_ADDR:
            state_nxt = (opcode == OP_LD) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:
            if (bus.mem_ready) state_nxt = S_MEM_WB;
         S_MEM_WB:    state_nxt = S_FETCH;
         S_MEM_WRITE:
            if (bus.mem_ready) state_nxt = S_FETCH;
         S_R_EXEC:    state_nxt = S_R_WB;
         S_R_WB:      state_nxt = S_FETCH;
         S_BRANCH:    state_nxt = S_FETCH;
`ifdef RV_CTRL_ADDI_EN
         S_I_EXEC:    state_nxt = S_R_WB;
`endif
         default:     state_nxt = S_HALT;
      endcase
      // A watchdog timeout abandons the access from any wait state.
      if (wd_expire) state_nxt = S_HALT;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         if (set_illegal) illegal <= 1'b1;
      end
   end

   always_comb begin
      c = '0;
      unique case (state)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRC_B_FOUR;
            c.alu_op    = ALU_ADD;
         end
         S_DECODE: begin
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_MEM_READ: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRC_B_REG;
            c.alu_op    = ALU_FUNCT;
         end
         S_R_WB:
            c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRC_B_REG;
            c.alu_op    = ALU_SUB;
            c.pc_src    = 1'b1;
         end
`ifdef RV_CTRL_ADDI_EN
         S_I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ADD;
         end
`endif
         default: c = '0;
      endcase
   end

   assign alu_op        = c.alu_op;
   assign alu_src_a     = c.alu_src_a;
   assign alu_src_b     = c.alu_src_b;
   assign pc_src        = c.pc_src;
   assign reg_write     = c.reg_write;
   assign mem_to_reg    = c.mem_to_reg;
   assign bus.mem_read  = c.mem_read;
   assign bus.mem_write = c.mem_write;
   assign bus.iord      = c.iord;

   // The only Mealy terms: fetch completion and the taken branch.
   assign ir_write = (state == S_FETCH) & bus.mem_ready;
   assign pc_write = ((state == S_FETCH) & bus.mem_ready)
                   | ((state == S_BRANCH) & zero);

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed vectors, corner sequences and a
// randomized run against an instruction-level model of the controller.
module tb_rv_multicycle_ctrl;

   localparam int LIMIT = 4;

   localparam int F   = 0;
   localparam int D   = 1;
   localparam int MA  = 2;
   localparam int MR  = 3;
   localparam int MWB = 4;
   localparam int MW  = 5;
   localparam int RE  = 6;
   localparam int RW  = 7;
   localparam int BR  = 8;
   localparam int H   = 9;
   localparam int IE  = 10;

   localparam logic [6:0] LD   = 7'b0000011;
   localparam logic [6:0] SD   = 7'b0100011;
   localparam logic [6:0] RT   = 7'b0110011;
   localparam logic [6:0] BEQ  = 7'b1100011;
   localparam logic [6:0] ADDI = 7'b0010011;
   localparam logic [6:0] BAD  = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic       zero = 1'b0;
   logic [1:0] alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       ir_write;
   logic       pc_write;
   logic       pc_src;
   logic       reg_write;
   logic       mem_to_reg;
   logic       illegal;
   logic       bus_error;
   logic [3:0] state;

   rv_multicycle_ctrl_if bus ();

   rv_multicycle_ctrl #(
      .WAIT_LIMIT (LIMIT),
      .CNT_W      (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .zero       (zero),
      .bus        (bus),
      .alu_op     (alu_op),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .illegal    (illegal),
      .bus_error  (bus_error),
      .state      (state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic [1:0] alu_op;
      logic       src_a;
      logic [1:0] src_b;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       reg_write;
      logic       mem_to_reg;
      logic       illegal;
      logic       bus_error;
   } obs_t;

   typedef struct {
      logic [6:0] op;
      logic       z;
      int         mem_wait;
      int         cyc;
      int         pcw;
      int         rgw;
      logic       ill;
      logic       be;
      int         fin;
   } vec_t;

   int nchk = 0;
   int nerr = 0;

   function automatic obs_t expect_out(int s, logic mr, logic z,
                                       logic ill, logic be);
      obs_t o;
      o           = '0;
      o.st        = 4'(s);
      o.illegal   = ill;
      o.bus_error = be;
      case (s)
         F: begin
            o.mem_read = 1'b1;
            o.src_b    = 2'b01;
            o.ir_write = mr;
            o.pc_write = mr;
         end
         D:  o.src_b = 2'b10;
         MA: begin o.src_a = 1'b1; o.src_b = 2'b10; end
         MR: begin o.mem_read = 1'b1; o.iord = 1'b1; end
         MWB: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
         MW: begin o.mem_write = 1'b1; o.iord = 1'b1; end
         RE: begin o.src_a = 1'b1; o.alu_op = 2'b10; end
         RW: o.reg_write = 1'b1;
         BR: begin
            o.src_a    = 1'b1;
            o.alu_op   = 2'b01;
            o.pc_src   = 1'b1;
            o.pc_write = z;
         end
         IE: begin o.src_a = 1'b1; o.src_b = 2'b10; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.st         = state;
      o.alu_op     = alu_op;
      o.src_a      = alu_src_a;
      o.src_b      = alu_src_b;
      o.iord       = bus.iord;
      o.mem_read   = bus.mem_read;
      o.mem_write  = bus.mem_write;
      o.ir_write   = ir_write;
      o.pc_write   = pc_write;
      o.pc_src     = pc_src;
      o.reg_write  = reg_write;
      o.mem_to_reg = mem_to_reg;
      o.illegal    = illegal;
      o.bus_error  = bus_error;
      return o;
   endfunction

   task automatic chk(string nm, int got, int exp);
      nchk++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
      end
   endtask

   task automatic chk_obs(string nm, obs_t got, obs_t exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got=%05h expected=%05h", nm, got, exp);
      end
   endtask

   // Advance one clock; leaves time at negedge+1.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.mem_ready = 1'b0;
      tick();
      reset = 1'b0;
      chk_obs("reset_state", observe(), expect_out(F, 1'b0, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic run_vec(vec_t v, int n);
      int cyc;
      int pcw;
      int rgw;
      int left;
      cyc  = 0;
      pcw  = 0;
      rgw  = 0;
      left = v.mem_wait;
      do_reset();
      opcode = v.op;
      zero   = v.z;
      do begin
         if ((int'(state) == MR || int'(state) == MW) && left > 0) begin
            bus.mem_ready = 1'b0;
            left--;
         end else begin
            bus.mem_ready = 1'b1;
         end
         #1;
         pcw += int'(pc_write);
         rgw += int'(reg_write);
         cyc++;
         tick();
      end while (int'(state) != F && int'(state) != H && cyc < 40);
      chk($sformatf("vec%0d_cycles", n), cyc, v.cyc);
      chk($sformatf("vec%0d_pc_writes", n), pcw, v.pcw);
      chk($sformatf("vec%0d_reg_writes", n), rgw, v.rgw);
      chk($sformatf("vec%0d_illegal", n), int'(illegal), int'(v.ill));
      chk($sformatf("vec%0d_bus_error", n), int'(bus_error), int'(v.be));
      chk($sformatf("vec%0d_end_state", n), int'(state), v.fin);
   endtask

   // Instruction-level model: each instruction is its list of phases;
   // FETCH/MEM_READ/MEM_WRITE phases hold until mem_ready or timeout.
   int         plan[$];
   int         idx;
   int         ms;
   int         wcnt;
   logic       m_ill;
   logic       m_be;
   logic [6:0] cur_op;

   task automatic new_instr();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2)       cur_op = LD;
      else if (r < 4)  cur_op = SD;
      else if (r < 6)  cur_op = RT;
      else if (r < 8)  cur_op = BEQ;
      else if (r == 8) cur_op = ADDI;
      else begin
         cur_op = 7'($urandom);
         if (cur_op == LD || cur_op == SD || cur_op == RT ||
             cur_op == BEQ || cur_op == ADDI)
            cur_op = BAD;
      end
      plan = '{F, D};
      if (cur_op == LD) begin
         plan.push_back(MA); plan.push_back(MR); plan.push_back(MWB);
      end else if (cur_op == SD) begin
         plan.push_back(MA); plan.push_back(MW);
      end else if (cur_op == RT) begin
         plan.push_back(RE); plan.push_back(RW);
      end else if (cur_op == BEQ) begin
         plan.push_back(BR);
`ifdef RV_CTRL_ADDI_EN
      end else if (cur_op == ADDI) begin
         plan.push_back(IE); plan.push_back(RW);
`endif
      end else begin
         plan.push_back(H);
      end
      idx = 0;
   endtask

   task automatic model_reset();
      m_ill = 1'b0;
      m_be  = 1'b0;
      wcnt  = 0;
      new_instr();
      ms = plan[0];
   endtask

   task automatic advance();
      idx++;
      if (idx >= plan.size()) new_instr();
      ms = plan[idx];
      if (ms == H) m_ill = 1'b1;
   endtask

   task automatic model_step(logic mr);
      if (ms == H) return;
      if (ms == F || ms == MR || ms == MW) begin
         if (mr) begin
            wcnt = 0;
            advance();
         end else begin
            wcnt++;
            if (wcnt == LIMIT) begin
               ms   = H;
               m_be = 1'b1;
               wcnt = 0;
            end
         end
      end else begin
         advance();
      end
   endtask

   vec_t vt[11];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic mr;
      logic zr;
      int   hcnt;

      vt[0]  = '{RT,   1'b0, 0, 4, 1, 1, 1'b0, 1'b0, F};
      vt[1]  = '{BEQ,  1'b1, 0, 3, 2, 0, 1'b0, 1'b0, F};
      vt[2]  = '{BEQ,  1'b0, 0, 3, 1, 0, 1'b0, 1'b0, F};
      vt[3]  = '{SD,   1'b0, 0, 4, 1, 0, 1'b0, 1'b0, F};
      vt[4]  = '{LD,   1'b0, 0, 5, 1, 1, 1'b0, 1'b0, F};
      vt[5]  = '{LD,   1'b0, 3, 8, 1, 1, 1'b0, 1'b0, F};
      vt[6]  = '{SD,   1'b0, 3, 7, 1, 0, 1'b0, 1'b0, F};
      vt[7]  = '{SD,   1'b0, 4, 7, 1, 0, 1'b0, 1'b1, H};
      vt[8]  = '{BAD,  1'b0, 0, 2, 1, 0, 1'b1, 1'b0, H};
`ifdef RV_CTRL_ADDI_EN
      vt[9]  = '{ADDI, 1'b0, 0, 4, 1, 1, 1'b0, 1'b0, F};
`else
      vt[9]  = '{ADDI, 1'b0, 0, 2, 1, 0, 1'b1, 1'b0, H};
`endif
      vt[10] = '{LD,   1'b0, 4, 7, 1, 0, 1'b0, 1'b1, H};

      bus.mem_ready = 1'b0;
      for (int i = 0; i < 11; i++) run_vec(vt[i], i);

      // Watchdog in FETCH: four stalled cycles then HALT.
      do_reset();
      opcode = RT;
      for (int i = 0; i < LIMIT; i++) begin
         bus.mem_ready = 1'b0;
         #1;
         chk_obs($sformatf("fetch_wait%0d", i), observe(),
                 expect_out(F, 1'b0, 1'b0, 1'b0, 1'b0));
         tick();
      end
      chk_obs("fetch_wd_halt", observe(),
              expect_out(H, 1'b0, 1'b0, 1'b0, 1'b1));
      bus.mem_ready = 1'b1;
      tick();
      chk_obs("halt_sticky", observe(),
              expect_out(H, 1'b1, 1'b0, 1'b0, 1'b1));

      // Reset during a stalled MEM_WRITE also clears the wait count.
      do_reset();
      opcode        = SD;
      bus.mem_ready = 1'b1;
      tick();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      #1;
      chk_obs("mw_wait", observe(), expect_out(MW, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_obs("mw_reset", observe(), expect_out(F, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
      tick();
      tick();
      chk_obs("post_reset_wait", observe(),
              expect_out(F, 1'b0, 1'b0, 1'b0, 1'b0));
      bus.mem_ready = 1'b1;
      tick();
      chk_obs("post_reset_fetch", observe(),
              expect_out(D, 1'b1, 1'b0, 1'b0, 1'b0));

      // Randomized run against the model.
      model_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      hcnt  = 0;
      for (int i = 0; i < 600; i++) begin
         mr = ($urandom_range(0, 99) < 65);
         zr = 1'($urandom_range(0, 1));
         opcode        = cur_op;
         bus.mem_ready = mr;
         zero          = zr;
         #1;
         chk_obs($sformatf("rnd%0d", i), observe(),
                 expect_out(ms, mr, zr, m_ill, m_be));
         model_step(mr);
         tick();
         if (ms == H) hcnt++;
         if (hcnt > 2) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            model_reset();
            hcnt = 0;
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle RISC-V control FSM that sequences the shared datapath: one ALU, one unified memory port, the register file, PC and IR. Per state it drives alu_op[1:0] into the existing ALU-control decoder (00 add, 01 sub, 10 funct-decoded), plus the mux selects and write enables. Supported instructions: ld, sd, R-type (add/sub/and/or) and beq. It waits on a memory-ready handshake and has a memory watchdog.

Parameters:
WAIT_LIMIT, 16, max consecutive cycles waiting on mem_ready before bus_error; 0 disables the watchdog.
CNT_W, 5, watchdog counter width; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  7  IR[6:0], stable from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
alu_op  out  2  to ALU-control decoder
alu_src_a  out  1  0 = PC, 1 = regA
alu_src_b  out  2  00 = regB, 01 = const 4, 10 = imm
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  1  0 = ALU result, 1 = ALUOut (branch target)
reg_write  out  1  register-file write enable
mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
illegal  out  1  sticky: undecodable opcode
bus_error  out  1  sticky: watchdog expired
state  out  4  current state encoding, for debug

Behaviour:
- Moore FSM. All outputs are a function of state only, except ir_write, pc_write and wait-state exits, which are qualified by mem_ready or zero as listed below.
- Reset: state = FETCH, watchdog count = 0, illegal = 0, bus_error = 0. Every output not active in FETCH is 0.
- Reset asserted in any state, including a memory wait, returns the FSM to FETCH on the next edge. It also clears the sticky flags and the watchdog count.
- Reset has priority over every other event.
- Default for unlisted outputs in each state: 0.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=0.
  - ir_write and pc_write = mem_ready. This is the only combinational qualification in this state.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=10, alu_op=00, computing the branch target into ALUOut.
  - Next state by opcode: 0000011 or 0100011 -> MEM_ADDR; 0110011 -> R_EXEC; 1100011 -> BRANCH; any other -> HALT with illegal set.
- MEM_ADDR:
  - Drives alu_src_a=1, alu_src_b=10, alu_op=00.
  - opcode 0000011 -> MEM_READ; otherwise -> MEM_WRITE.
- MEM_READ: drives mem_read=1, iord=1. mem_ready -> MEM_WB; otherwise stay.
- MEM_WB: drives reg_write=1, mem_to_reg=1. -> FETCH.
- MEM_WRITE: drives mem_write=1, iord=1. mem_ready -> FETCH; otherwise stay.
- R_EXEC: drives alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
- R_WB: drives reg_write=1, mem_to_reg=0. -> FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_write = zero.
  - -> FETCH.
- HALT: all strobes 0. Stays in HALT until reset.
- Cycle counts with mem_ready asserted immediately:
  - R-type: 4 cycles
  - beq: 3 cycles
  - sd: 4 cycles
  - ld: 5 cycles
- Watchdog:
  - Counts cycles spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Clears on mem_ready or on leaving the wait state.
  - When the count reaches WAIT_LIMIT (WAIT_LIMIT>0): set bus_error, deassert all strobes, go to HALT on that edge.
  - If mem_ready arrives in the same cycle the count reaches WAIT_LIMIT, mem_ready wins: no error.
- The count saturates and never wraps.

Optional Feature:
Macro RV_CTRL_ADDI_EN.
- Defined: opcode 0010011 (addi) is decoded in DECODE and goes to I_EXEC, then R_WB.
  - I_EXEC drives alu_src_a=1, alu_src_b=10, alu_op=00.
  - addi takes 4 cycles.
- Undefined: 0010011 is illegal, exactly like any other unsupported opcode.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state encoding constants (FETCH=0 … HALT=9, I_EXEC=10);
  - opcode constants OP_LD, OP_SD, OP_R, OP_BEQ, OP_ADDI;
  - alu_op constants ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10;
  - alu_src_b select constants.
- One natural sub-module: rv_ctrl_watchdog, containing the saturating counter, compare and sticky bus_error.
- Next-state logic and output decode stay in the top module.

Test Plan:
- Reset then R-type, opcode 0110011, mem_ready held 1 -> states FETCH, DECODE, R_EXEC, R_WB, FETCH; alu_op=10 in R_EXEC; reg_write=1 only in R_WB.
- ld, opcode 0000011, with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB with reg_write=1, mem_to_reg=1; bus_error=0.
- beq with zero=1, then zero=0 -> pc_write=1, pc_src=1, alu_op=01 in BRANCH for the first; pc_write=0 for the second; both return to FETCH.
- Opcode 1111111 -> DECODE goes to HALT and illegal=1. Issue reset -> FETCH, illegal=0.
- WAIT_LIMIT=4, sd with mem_ready low -> bus_error=1 and HALT after 4 wait cycles, mem_write=0 in HALT. A repeat with mem_ready arriving on wait cycle 4 -> no error.
- Reset asserted mid-MEM_WRITE -> next cycle state=FETCH, mem_write=0. Opcode 0010011 -> I_EXEC then R_WB with the macro defined; illegal with it undefined.
